// File: rtl/rotate_pkg.sv
// rtl/rotate_pkg.sv - shared widths, FSM state type and result helpers for rotate_detect
package rotate_pkg;

    localparam int DATA_W = 8;
    localparam int AMT_W  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Left rotation by k expressed as the shorter path: {lr, amt}, tie at half-width reports left
    function automatic logic [AMT_W:0] k_to_result(input logic [AMT_W-1:0] k);
        logic [AMT_W:0] r;
        if (int'(k) <= DATA_W / 2) begin
            r = {1'b0, k};
        end else begin
            r = {1'b1, AMT_W'(DATA_W - int'(k))};
        end
        return r;
    endfunction

    function automatic logic [AMT_W-1:0] lowest_set(input logic [DATA_W-1:0] m);
        logic [AMT_W-1:0] r;
        r = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (m[i]) begin
                r = AMT_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rotate_left.sv
// rtl/rotate_left.sv - combinational rotate-left barrel shifter
module rotate_left #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic [W-1:0]  a,
    input  logic [AW-1:0] amt,
    output logic [W-1:0]  y
);

    logic [2*W-1:0] dbl;

    always_comb begin
        dbl = {a, a} >> (W - int'(amt));
        y   = dbl[W-1:0];
    end

endmodule

// File: rtl/rotate_detect.sv
// rtl/rotate_detect.sv - finds the rotation that maps a onto y; ROTATE_DETECT_MATCH_MASK_EN adds match_mask
module rotate_detect
    import rotate_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] y,
    output logic              ready,
    output logic              done,
    output logic              found,
    output logic [AMT_W-1:0]  amt,
`ifdef ROTATE_DETECT_MATCH_MASK_EN
    output logic              lr,
    output logic [DATA_W-1:0] match_mask
`else
    output logic              lr
`endif
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   y_q, y_d;
    logic [AMT_W-1:0]    k_q, k_d;
    logic                found_q, found_d;
    logic [AMT_W-1:0]    amt_q, amt_d;
    logic                lr_q, lr_d;
    logic [DATA_W-1:0]   cand;
    logic                match;
    logic                last_k;
`ifdef ROTATE_DETECT_MATCH_MASK_EN
    logic [DATA_W-1:0]   mask_q, mask_d;
`endif

    rotate_left #(
        .W  (DATA_W),
        .AW (AMT_W)
    ) u_rotate_left (
        .a   (a_q),
        .amt (k_q),
        .y   (cand)
    );

    assign match  = (cand == y_q);
    assign last_k = (k_q == AMT_W'(DATA_W - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        y_d     = y_q;
        k_d     = k_q;
        found_d = found_q;
        amt_d   = amt_q;
        lr_d    = lr_q;
`ifdef ROTATE_DETECT_MATCH_MASK_EN
        mask_d  = mask_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    y_d     = y;
                    k_d     = '0;
`ifdef ROTATE_DETECT_MATCH_MASK_EN
                    mask_d  = '0;
`endif
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
`ifdef ROTATE_DETECT_MATCH_MASK_EN
                // Full scan: the result is decided from the complete mask on the last candidate
                if (match) begin
                    mask_d[k_q] = 1'b1;
                end
                if (last_k) begin
                    found_d       = |mask_d;
                    {lr_d, amt_d} = k_to_result(lowest_set(mask_d));
                    state_d       = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
`else
                if (match) begin
                    found_d       = 1'b1;
                    {lr_d, amt_d} = k_to_result(k_q);
                    state_d       = DONE;
                end else if (last_k) begin
                    found_d = 1'b0;
                    amt_d   = '0;
                    lr_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            y_q     <= '0;
            k_q     <= '0;
            found_q <= 1'b0;
            amt_q   <= '0;
            lr_q    <= 1'b0;
`ifdef ROTATE_DETECT_MATCH_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            y_q     <= y_d;
            k_q     <= k_d;
            found_q <= found_d;
            amt_q   <= amt_d;
            lr_q    <= lr_d;
`ifdef ROTATE_DETECT_MATCH_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = (state_q == DONE);
    assign found = found_q;
    assign amt   = amt_q;
    assign lr    = lr_q;
`ifdef ROTATE_DETECT_MATCH_MASK_EN
    assign match_mask = mask_q;
`endif

endmodule

// File: tb/tb_rotate_detect.sv
// tb/tb_rotate_detect.sv - directed and randomized checks of rotate_detect against a behavioural model
module tb_rotate_detect;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] y;
    logic       ready;
    logic       done;
    logic       found;
    logic [2:0] amt;
    logic       lr;
`ifdef ROTATE_DETECT_MATCH_MASK_EN
    logic [7:0] match_mask;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rotate_detect dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .a          (a),
        .y          (y),
        .ready      (ready),
        .done       (done),
        .found      (found),
        .amt        (amt),
`ifdef ROTATE_DETECT_MATCH_MASK_EN
        .lr         (lr),
        .match_mask (match_mask)
`else
        .lr         (lr)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rotl_m(input logic [7:0] v, input int k);
        logic [15:0] t;
        t = {v, v} << k;
        return t[15:8];
    endfunction

    function automatic logic [7:0] rotr_m(input logic [7:0] v, input int k);
        logic [15:0] t;
        t = {v, v} >> k;
        return t[7:0];
    endfunction

    typedef struct packed {
        logic       f;
        logic       lr;
        logic [2:0] amt;
        logic [7:0] mask;
    } res_t;

    // Shortest rotation: try left 0..4 first, then right 1..3
    function automatic res_t model_calc(input logic [7:0] va, input logic [7:0] vy);
        res_t r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            if (rotl_m(va, k) == vy) r.mask[k] = 1'b1;
        end
        for (int d = 0; d <= 4; d++) begin
            if (!r.f && rotl_m(va, d) == vy) begin
                r.f = 1'b1; r.amt = 3'(d); r.lr = 1'b0;
            end
        end
        for (int d = 1; d <= 3; d++) begin
            if (!r.f && rotr_m(va, d) == vy) begin
                r.f = 1'b1; r.amt = 3'(d); r.lr = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic int model_lat(input logic [7:0] va, input logic [7:0] vy);
        res_t r;
        r = model_calc(va, vy);
`ifdef ROTATE_DETECT_MATCH_MASK_EN
        return 9;
`else
        if (!r.f) return 9;
        return (r.lr ? 8 - int'(r.amt) : int'(r.amt)) + 2;
`endif
    endfunction

    function automatic int exp_cyc(input int k);
`ifdef ROTATE_DETECT_MATCH_MASK_EN
        return 9;
`else
        return k + 2;
`endif
    endfunction

    // Model: phase 0 idle, 1 searching, 2 done cycle
    int   m_phase  = 0;
    int   m_remain = 0;
    bit   m_live   = 1'b0;
    bit   m_valid  = 1'b0;
    res_t m_pend   = '0;
    res_t m_res    = '0;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_live   <= 1'b1;
            m_phase  <= 0;
            m_remain <= 0;
            m_valid  <= 1'b1;
            m_res    <= '0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_pend   <= model_calc(a, y);
                    m_remain <= model_lat(a, y) - 1;
                    m_phase  <= 1;
                    m_valid  <= 1'b0;
                end
                1: begin
                    if (m_remain == 1) begin
                        m_phase <= 2;
                        m_res   <= m_pend;
                        m_valid <= 1'b1;
                    end
                    m_remain <= m_remain - 1;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("model_ready", int'(ready), int'(m_phase == 0));
            chk("model_done", int'(done), int'(m_phase == 2));
            if (m_valid) begin
                chk("model_found", int'(found), int'(m_res.f));
                chk("model_amt", int'(amt), int'(m_res.amt));
                chk("model_lr", int'(lr), int'(m_res.lr));
`ifdef ROTATE_DETECT_MATCH_MASK_EN
                chk("model_mask", int'(match_mask), int'(m_res.mask));
`endif
            end
        end
    end

    task automatic run_op(input logic [7:0] ta, input logic [7:0] ty, input bit stray, output int cyc);
        @(negedge clk);
        chk("ready_at_start", int'(ready), 1);
        a = ta; y = ty; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = 8'($urandom); y = 8'($urandom);
        cyc = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (stray) start = 1'($urandom_range(0, 1));
            if (done) begin
                cyc = n + 1;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_result(input string name, input int cyc, input int ec,
                                input int ef, input int ea, input int el);
        chk({name, "_cycle"}, cyc, ec);
        chk({name, "_found"}, int'(found), ef);
        chk({name, "_amt"}, int'(amt), ea);
        chk({name, "_lr"}, int'(lr), el);
    endtask

    initial begin
        int cyc;
        int dcount;
        logic [7:0] ra;
        reset_n = 1'b0; start = 1'b0; a = '0; y = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk("reset_ready", int'(ready), 1);
        chk("reset_done", int'(done), 0);
        chk("reset_found", int'(found), 0);
        chk("reset_amt", int'(amt), 0);
        chk("reset_lr", int'(lr), 0);

        run_op(8'hB1, 8'h8D, 1'b0, cyc);
        check_result("left3", cyc, exp_cyc(3), 1, 3, 0);
        run_op(8'hB1, 8'h6C, 1'b0, cyc);
        check_result("right2", cyc, exp_cyc(6), 1, 2, 1);

        // Abort mid-search with reset; results from the previous op must clear
        @(negedge clk);
        a = 8'h01; y = 8'h03; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        start   = 1'b0;
        chk("abort_ready", int'(ready), 1);
        chk("abort_done", int'(done), 0);
        chk("abort_found", int'(found), 0);
        chk("abort_amt", int'(amt), 0);
        chk("abort_lr", int'(lr), 0);
        dcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("abort_no_done", dcount, 0);

        run_op(8'h81, 8'h81, 1'b0, cyc);
        check_result("same", cyc, exp_cyc(0), 1, 0, 0);
        run_op(8'h3C, 8'hF0, 1'b0, cyc);
        check_result("back_to_back", cyc, exp_cyc(2), 1, 2, 0);
        run_op(8'h01, 8'h03, 1'b1, cyc);
        check_result("nomatch", cyc, 9, 0, 0, 0);
`ifdef ROTATE_DETECT_MATCH_MASK_EN
        run_op(8'hAA, 8'h55, 1'b0, cyc);
        check_result("mask_aa", cyc, 9, 1, 1, 0);
        chk("mask_aa_mask", int'(match_mask), 8'hAA);
`endif

        repeat (3000) begin
            @(negedge clk);
            reset_n = ($urandom_range(0, 99) != 0);
            start   = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 5))
                0:       ra = 8'hAA;
                1:       ra = 8'h33;
                default: ra = 8'($urandom);
            endcase
            a = ra;
            case ($urandom_range(0, 3))
                0:       y = rotl_m(ra, $urandom_range(0, 7));
                1:       y = rotr_m(ra, $urandom_range(0, 7));
                2:       y = ra;
                default: y = 8'($urandom);
            endcase
        end
        @(negedge clk);
        reset_n = 1'b1; start = 1'b0;
        repeat (12) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rotate_detect.md
ROTATE_DETECT -- requirements
Module: rotate_detect

Interface
REQ-001 Parameters: none; data width is fixed at 8 and rotation amount width at 3.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 start  input  1  request; accepted only when ready=1.
REQ-005 a  input  8  original word, sampled on acceptance.
REQ-006 y  input  8  rotated word, sampled on acceptance.
REQ-007 ready  output  1  high in IDLE only.
REQ-008 done  output  1  one-cycle pulse when a result is valid.
REQ-009 found  output  1  1 = y is a rotation of a.
REQ-010 amt  output  3  rotation amount, minimum-distance form.
REQ-011 lr  output  1  direction: 0 = left, 1 = right.

Function
REQ-012 Block shall find the rotation (amt, lr) such that rotating a by amt in direction lr yields y; it is the inverse of the team's rotate-left/right barrel shifter.
REQ-013 FSM shall have states IDLE, SEARCH and DONE.
REQ-014 IDLE: start=1 shall capture a and y, clear k to 0, and go to SEARCH.
REQ-015 SEARCH: each cycle shall compare rotl(a_reg, k) with y_reg, one candidate per cycle, k ascending from 0.
REQ-016 On a match at k, the block shall record the result and go to DONE.
REQ-017 With no match and k=7, the block shall set found=0, amt=0, lr=0 and go to DONE; otherwise k shall increment.
REQ-018 Result conversion: k<=4 shall give lr=0, amt=k; k>=5 shall give lr=1, amt=8-k. The tie at k=4 reports left.
REQ-019 DONE: done=1 for exactly one cycle, then the FSM shall return to IDLE.
REQ-020 Latency: done shall assert k+2 cycles after the accepting edge on a match at k, and 9 cycles after it on no match.
REQ-021 found, amt and lr shall hold their values from done until the next accepted start.
REQ-022 start while ready=0 shall be ignored; a and y changes after acceptance shall have no effect.
REQ-023 Start in the cycle after done shall be accepted, because the FSM is back in IDLE.

Reset
REQ-024 reset_n=0 at a clock edge shall force IDLE, ready=1, done=0, found=0, amt=0, lr=0 and k=0, plus match_mask=0 when the mask is compiled in.
REQ-025 Reset during SEARCH or DONE shall abort the operation with no done pulse; reset shall have priority over start.

Configuration
REQ-026 Macro ROTATE_DETECT_MATCH_MASK_EN shall add output match_mask[7:0], where bit k=1 iff rotl(a,k)=y.
REQ-027 With the macro defined, SEARCH shall always scan all 8 candidates, with no early exit.
REQ-028 With the macro defined, done shall come 9 cycles after acceptance, and the amt/lr result shall come from the lowest matching k.
REQ-029 With the macro defined, match_mask shall hold its value with the other results.
REQ-030 Without the macro, the port and mask logic shall be absent and REQ-016 early exit shall apply.

Structure
REQ-031 Shared package rotate_pkg shall hold DATA_W=8, AMT_W=3 and the state enum typedef (IDLE, SEARCH, DONE).
REQ-032 The candidate rotation shall instantiate the team's existing rotate_left unit, fed by (a_reg, k); no other sub-modules.

Verification
REQ-033 The bench shall cover these directed scenarios:
- a=8'hB1, y=8'h8D -> done at cycle 5, found=1, amt=3, lr=0.
- a=8'hB1, y=8'h6C (right by 2) -> done at cycle 8, found=1, amt=2, lr=1.
- a=8'h81, y=8'h81 -> done at cycle 2, found=1, amt=0, lr=0; then start on the cycle after done is accepted.
- a=8'h01, y=8'h03 -> done at cycle 9, found=0, amt=0, lr=0; start pulses during SEARCH are ignored.
- reset_n=0 at cycle 3 of a search -> no done pulse, ready=1 next cycle, all outputs 0.
- Macro on, a=8'hAA, y=8'h55 -> done at cycle 9, match_mask=8'hAA, found=1, amt=1, lr=0.
